// File: rtl/key_pkg.sv
// Shared types and sizing helpers for the key conditioner channels.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REPEAT,
    REL_DB
  } key_state_t;

  // Counter must reach the largest terminal value used by any phase.
  function automatic int cnt_width(input int db, input int rd, input int rr);
    int m;
    m = db;
    if (rd > m) m = rd;
    if (rr > m) m = rr;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: synchroniser, debounce/repeat FSM and shared phase counter.
module key_channel
  import key_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  input  logic en_repeat_i,
  output logic out_o,
  output logic held_o,
  output logic rel_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  key_state_t             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   held_q, held_d;
  logic                   rel_q, rel_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      held_q  <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      held_q  <= held_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = HELD;
            out_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = PRESS_DB;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PRESS_DB: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          out_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD, REPEAT: begin
        // With single-cycle debounce a release is accepted on its first low sample,
        // mirroring the press path so both latencies stay equal.
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = IDLE;
            rel_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = REL_DB;
            cnt_d   = CNT_ONE;
          end
        end else if (!en_repeat_i) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == ((state_q == HELD) ? RD_LAST : RR_LAST)) begin
          state_d = REPEAT;
          out_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REL_DB: begin
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == REL_DB);
  end

  assign out_o  = out_q;
  assign held_o = held_q;
  assign rel_o  = rel_q;

endmodule

// File: rtl/key_conditioner.sv
// Multi-channel pushbutton conditioner: synchronise, debounce, press/release pulses, auto-repeat.
module key_conditioner
  import key_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] in,
  input  logic              en_repeat,
  output logic [N_KEYS-1:0] out,
  output logic [N_KEYS-1:0] held,
  output logic [N_KEYS-1:0] rel
);

  if (N_KEYS < 1)          $error("N_KEYS must be >= 1");
  if (SYNC_STAGES < 2)     $error("SYNC_STAGES must be >= 2");
  if (DEBOUNCE_CYCLES < 1) $error("DEBOUNCE_CYCLES must be >= 1");
  if (REPEAT_DELAY < 1)    $error("REPEAT_DELAY must be >= 1");
  if (REPEAT_RATE < 1)     $error("REPEAT_RATE must be >= 1");

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .raw_i      (in[g]),
      .en_repeat_i(en_repeat),
      .out_o      (out[g]),
      .held_o     (held[g]),
      .rel_o      (rel[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench: directed scenarios plus random stimulus against a run-length reference model.
module tb_key_conditioner;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int RD = 16;
  localparam int RR = 4;
  localparam int P  = SS + DB - 1;  // tick index of the press pulse after the first sampling edge

  logic         clk = 1'b0;
  logic         reset;
  logic         en_repeat;
  logic [N-1:0] in_r;
  logic [N-1:0] out_w, held_w, rel_w;

  always #5 clk = ~clk;

  key_conditioner #(
    .N_KEYS(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .reset(reset), .in(in_r), .en_repeat(en_repeat),
    .out(out_w), .held(held_w), .rel(rel_w)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: synchronised level, accepted level, length of the current
  // disagreeing run, and length of the current held-with-repeat-enabled run.
  logic [SS-1:0] m_sync [N];
  bit            m_lvl  [N];
  int            m_mis  [N];
  int            m_run  [N];
  logic [N-1:0]  exp_out, exp_held, exp_rel;

  task automatic tick();
    for (int i = 0; i < N; i++) begin
      if (!reset) begin
        m_sync[i] = '0; m_lvl[i] = 0; m_mis[i] = 0; m_run[i] = 0;
        exp_out[i] = 1'b0; exp_held[i] = 1'b0; exp_rel[i] = 1'b0;
      end else begin
        bit s;
        s = m_sync[i][SS-1];
        exp_out[i] = 1'b0;
        exp_rel[i] = 1'b0;
        if (s != m_lvl[i]) begin
          m_mis[i]++;
          if (m_mis[i] == DB) begin
            m_lvl[i] = s; m_mis[i] = 0; m_run[i] = 0;
            if (s) exp_out[i] = 1'b1; else exp_rel[i] = 1'b1;
          end
        end else if (m_mis[i] != 0) begin
          m_mis[i] = 0; m_run[i] = 0;
        end else if (m_lvl[i]) begin
          if (en_repeat) begin
            m_run[i]++;
            if (m_run[i] == RD || (m_run[i] > RD && (m_run[i] - RD) % RR == 0)) exp_out[i] = 1'b1;
          end else begin
            m_run[i] = 0;
          end
        end
        exp_held[i] = m_lvl[i];
        m_sync[i] = {m_sync[i][SS-2:0], in_r[i]};
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_r = 4'hF; en_repeat = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); vectors++;
      if ({out_w, held_w, rel_w} !== 12'h000) begin
        miscompares++;
        $display("FAIL reset_hold k=%0d out=%b held=%b rel=%b required 0", k, out_w, held_w, rel_w);
      end
    end
    reset = 1'b1;
    for (int k = 0; k < P; k++) begin
      tick(); vectors++;
      if ({out_w, held_w, rel_w} !== 12'h000) begin
        miscompares++;
        $display("FAIL reset_release k=%0d out=%b held=%b rel=%b required 0", k, out_w, held_w, rel_w);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick(); vectors++;
      if ({out_w, held_w, rel_w} !== {exp_out, exp_held, exp_rel}) begin
        miscompares++;
        $display("FAIL reset_model k=%0d out=%b/%b held=%b/%b rel=%b/%b", k, out_w, exp_out, held_w, exp_held, rel_w, exp_rel);
      end
    end
    in_r = '0; en_repeat = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(); vectors++;
      if ({out_w, held_w, rel_w} !== {exp_out, exp_held, exp_rel}) begin
        miscompares++;
        $display("FAIL reset_drain k=%0d out=%b/%b held=%b/%b rel=%b/%b", k, out_w, exp_out, held_w, exp_held, rel_w, exp_rel);
      end
    end
  endtask

  task automatic test_press();
    int n_out = 0, at_out = -1, at_rel = -1;
    en_repeat = 1'b0; in_r = 4'b0001;
    for (int k = 0; k < 10 + 12; k++) begin
      if (k == 10) in_r = '0;
      tick(); vectors++;
      if ({out_w, held_w, rel_w} !== {exp_out, exp_held, exp_rel}) begin
        miscompares++;
        $display("FAIL press k=%0d out=%b/%b held=%b/%b rel=%b/%b", k, out_w, exp_out, held_w, exp_held, rel_w, exp_rel);
      end
      if (out_w[0]) begin n_out++; at_out = k; end
      if (rel_w[0]) at_rel = k;
    end
    vectors++;
    if (n_out != 1 || at_out != P) begin
      miscompares++;
      $display("FAIL press_pulse count=%0d at=%0d required count=1 at=%0d", n_out, at_out, P);
    end
    vectors++;
    if (at_rel != 10 + P) begin
      miscompares++;
      $display("FAIL release_pulse at=%0d required %0d", at_rel, 10 + P);
    end
  endtask

  task automatic test_bounce();
    int n_out = 0, n_rel = 0, n_held = 0;
    en_repeat = 1'b0;
    for (int k = 0; k < 13; k++) begin
      in_r = (k < 3) ? 4'b0100 : 4'b0000;
      tick(); vectors++;
      if ({out_w, held_w, rel_w} !== {exp_out, exp_held, exp_rel}) begin
        miscompares++;
        $display("FAIL bounce k=%0d out=%b/%b held=%b/%b rel=%b/%b", k, out_w, exp_out, held_w, exp_held, rel_w, exp_rel);
      end
      if (out_w[2] | held_w[2] | rel_w[2]) n_held++;
    end
    vectors++;
    if (n_held != 0) begin
      miscompares++;
      $display("FAIL bounce_drop active_cycles=%0d required 0", n_held);
    end
    for (int k = 0; k < 36; k++) begin
      in_r = (k < 10 || (k >= 12 && k < 22)) ? 4'b0100 : 4'b0000;
      tick(); vectors++;
      if ({out_w, held_w, rel_w} !== {exp_out, exp_held, exp_rel}) begin
        miscompares++;
        $display("FAIL glitch k=%0d out=%b/%b held=%b/%b rel=%b/%b", k, out_w, exp_out, held_w, exp_held, rel_w, exp_rel);
      end
      if (out_w[2]) n_out++;
      if (rel_w[2]) n_rel++;
      if (k >= 10 && k < 22 + P) begin
        vectors++;
        if (held_w[2] !== 1'b1) begin
          miscompares++;
          $display("FAIL glitch_held k=%0d held=%b required 1", k, held_w[2]);
        end
      end
    end
    vectors++;
    if (n_out != 1 || n_rel != 1) begin
      miscompares++;
      $display("FAIL glitch_pulses out=%0d rel=%0d required 1 and 1", n_out, n_rel);
    end
  endtask

  task automatic test_repeat(input int drop_at);
    int got[$];
    int want[$];
    en_repeat = 1'b1; in_r = 4'b0010;
    for (int k = 0; k < 31 + 12; k++) begin
      if (k == 31) in_r = '0;
      if (k == drop_at) en_repeat = 1'b0;
      tick(); vectors++;
      if ({out_w, held_w, rel_w} !== {exp_out, exp_held, exp_rel}) begin
        miscompares++;
        $display("FAIL repeat k=%0d out=%b/%b held=%b/%b rel=%b/%b", k, out_w, exp_out, held_w, exp_held, rel_w, exp_rel);
      end
      if (out_w[1]) got.push_back(k);
    end
    if (drop_at < 0) want = '{P, P + RD, P + RD + RR, P + RD + 2 * RR};
    else             want = '{P, P + RD};
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL repeat_pulses drop=%0d got=%p required %p", drop_at, got, want);
    end
    en_repeat = 1'b0;
  endtask

  task automatic test_concurrency();
    int at3 = -1, at1 = -1;
    en_repeat = 1'b0; in_r = 4'b1010;
    for (int k = 0; k < 30; k++) begin
      if (k == 5)  in_r[3] = 1'b0;
      if (k == 15) in_r[1] = 1'b0;
      tick(); vectors++;
      if ({out_w, held_w, rel_w} !== {exp_out, exp_held, exp_rel}) begin
        miscompares++;
        $display("FAIL concur k=%0d out=%b/%b held=%b/%b rel=%b/%b", k, out_w, exp_out, held_w, exp_held, rel_w, exp_rel);
      end
      if (k == P) begin
        vectors++;
        if (out_w !== 4'b1010) begin
          miscompares++;
          $display("FAIL concur_press out=%b required 1010", out_w);
        end
      end
      if (rel_w[3]) at3 = k;
      if (rel_w[1]) at1 = k;
    end
    vectors++;
    if (at3 != 5 + P || at1 != 15 + P) begin
      miscompares++;
      $display("FAIL concur_rel rel3=%0d rel1=%0d required %0d and %0d", at3, at1, 5 + P, 15 + P);
    end
  endtask

  task automatic test_reset_mid();
    int n_rel = 0, at_out = -1;
    en_repeat = 1'b1; in_r = 4'b0010;
    for (int k = 0; k < 24; k++) begin
      tick(); vectors++;
      if ({out_w, held_w, rel_w} !== {exp_out, exp_held, exp_rel}) begin
        miscompares++;
        $display("FAIL rstmid_pre k=%0d out=%b/%b held=%b/%b rel=%b/%b", k, out_w, exp_out, held_w, exp_held, rel_w, exp_rel);
      end
    end
    reset = 1'b0;
    tick(); vectors++;
    if ({out_w, held_w, rel_w} !== 12'h000) begin
      miscompares++;
      $display("FAIL rstmid_clear out=%b held=%b rel=%b required 0", out_w, held_w, rel_w);
    end
    tick();
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(); vectors++;
      if ({out_w, held_w, rel_w} !== {exp_out, exp_held, exp_rel}) begin
        miscompares++;
        $display("FAIL rstmid_post k=%0d out=%b/%b held=%b/%b rel=%b/%b", k, out_w, exp_out, held_w, exp_held, rel_w, exp_rel);
      end
      if (rel_w[1]) n_rel++;
      if (out_w[1] && at_out < 0) at_out = k;
    end
    vectors++;
    if (n_rel != 0 || at_out != P) begin
      miscompares++;
      $display("FAIL rstmid_repress rel=%0d press_at=%0d required 0 and %0d", n_rel, at_out, P);
    end
    in_r = '0; en_repeat = 1'b0;
    for (int k = 0; k < 12; k++) tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 6 + 6 * i) == 0) in_r[i] = ~in_r[i];
      if ($urandom_range(0, 39) == 0) en_repeat = ~en_repeat;
      reset = ($urandom_range(0, 399) != 0);
      tick(); vectors++;
      if ({out_w, held_w, rel_w} !== {exp_out, exp_held, exp_rel}) begin
        miscompares++;
        $display("FAIL random k=%0d out=%b/%b held=%b/%b rel=%b/%b", k, out_w, exp_out, held_w, exp_held, rel_w, exp_rel);
      end
      vectors++;
      if ((out_w & rel_w) !== '0) begin
        miscompares++;
        $display("FAIL random_excl k=%0d out=%b rel=%b required disjoint", k, out_w, rel_w);
      end
    end
  endtask

  initial begin
    reset = 1'b0; in_r = '0; en_repeat = 1'b0;
    test_reset();
    test_press();
    test_bounce();
    test_repeat(-1);
    for (int k = 0; k < 4; k++) tick();
    test_repeat(P + RD + 2);
    for (int k = 0; k < 4; k++) tick();
    test_concurrency();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
